tdc_sample_ctrl: RTL and testbench

TDC_SAMPLE_CTRL -- requirements
Module: tdc_sample_ctrl

---
 rtl/tdc_sample_ctrl.sv | 114 +++++++++++
 tb/tb_tdc_sample_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tdc_sample_ctrl.sv
// TDC sampler: settles, samples and averages 2^AVG_LOG2 thermometer-code counts into one phase result.
// Build option TDC_BUBBLE_FIX_EN: count only the unbroken run of ones from bit 0, ignoring bubbles above it.
module tdc_sample_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int AVG_LOG2   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] tdc_code,
    output logic        busy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_data,
    output logic        sat
);
    localparam int NSMP = 1 << AVG_LOG2;
    localparam int AW   = 5 + AVG_LOG2;
    localparam int CW   = AVG_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t        state;
    state_t        nxt;
    logic [3:0]    settle_cnt;
    logic [CW-1:0] sample_cnt;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [5:0]    ones;
    logic [4:0]    smp_cnt;
    logic          smp_sat;
    logic          settle_last;
    logic          sample_last;

`ifdef TDC_BUBBLE_FIX_EN
    logic run;
    always_comb begin
        ones = '0;
        run  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (run && tdc_code[i]) ones = ones + 6'd1;
            else                    run  = 1'b0;
        end
    end
`else
    always_comb begin
        ones = '0;
        for (int i = 0; i < 32; i++) ones = ones + {5'd0, tdc_code[i]};
    end
`endif

    // Only a full 32-one code can reach 32; clamp it into the 5-bit range and flag it.
    assign smp_sat     = ones[5];
    assign smp_cnt     = smp_sat ? 5'd31 : ones[4:0];
    assign acc_nxt     = acc + AW'(smp_cnt);
    assign settle_last = (settle_cnt == 4'(SETTLE_CYC - 1));
    assign sample_last = (sample_cnt == CW'(NSMP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) nxt = SETTLE;
                SETTLE:  if (settle_last) nxt = SAMPLE;
                SAMPLE:  nxt = sample_last ? DONE : SETTLE;
                DONE:    if (res_ready) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        res_valid = (state == DONE);
    end

    // Abort freezes the datapath so res_data keeps the last completed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            res_data   <= '0;
            sat        <= 1'b0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        settle_cnt <= '0;
                        sample_cnt <= '0;
                        acc        <= '0;
                        sat        <= 1'b0;
                    end
                end
                SETTLE: settle_cnt <= settle_last ? 4'd0 : settle_cnt + 4'd1;
                SAMPLE: begin
                    acc        <= acc_nxt;
                    sample_cnt <= sample_cnt + CW'(1);
                    if (smp_sat)     sat      <= 1'b1;
                    if (sample_last) res_data <= acc_nxt[AW-1:AVG_LOG2];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tdc_sample_ctrl.sv
// Randomized and directed bench for tdc_sample_ctrl against a timeline-based measurement model.
module tb_tdc_sample_ctrl;
    localparam int S = 2;
    localparam int L = 2;
    localparam int N = 1 << L;
    localparam int T = N * (S + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        res_ready = 1'b0;
    logic [31:0] tdc_code = '0;
    logic        busy, res_valid, sat;
    logic [4:0]  res_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 idle, 1 measuring, 2 result pending; m_t counts edges since start.
    int m_mode = 0;
    int m_t    = 0;
    int m_sum  = 0;
    int m_res  = 0;
    bit m_sat  = 1'b0;

    tdc_sample_ctrl #(.SETTLE_CYC(S), .AVG_LOG2(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .tdc_code(tdc_code), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int code_count(input logic [31:0] c);
        int n;
        n = 0;
`ifdef TDC_BUBBLE_FIX_EN
        for (int i = 0; i < 32; i++) begin
            if (!c[i]) break;
            n++;
        end
`else
        n = $countones(c);
`endif
        return n;
    endfunction

    function automatic void model_edge(input logic s, input logic a, input logic r, input logic [31:0] c);
        int n;
        if (a) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (s) begin
                m_mode = 1; m_t = 0; m_sum = 0; m_sat = 1'b0;
            end
        end else if (m_mode == 1) begin
            if ((m_t % (S + 1)) == S) begin
                n = code_count(c);
                if (n == 32) begin n = 31; m_sat = 1'b1; end
                m_sum += n;
            end
            m_t++;
            if (m_t == T) begin
                m_mode = 2;
                m_res  = m_sum / N;
            end
        end else if (r) begin
            m_mode = 0;
        end
    endfunction

    function automatic bit is_sample_slot();
        return (m_mode == 1) && ((m_t % (S + 1)) == S);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".busy"},  32'(busy),      32'(m_mode != 0));
        chk({tag, ".valid"}, 32'(res_valid), 32'(m_mode == 2));
        chk({tag, ".data"},  32'(res_data),  32'(m_res));
        chk({tag, ".sat"},   32'(sat),       32'(m_sat));
    endtask

    task automatic step(input logic s, input logic a, input logic r, input logic [31:0] c, input string tag);
        start = s; abort = a; res_ready = r; tdc_code = c;
        @(posedge clk);
        model_edge(s, a, r, c);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [31:0] rand_code();
        int k;
        logic [31:0] one;
        one = 32'h1;
        k = $urandom_range(0, 3);
        if (k == 0) return $urandom();
        if (k == 1) return 32'hFFFF_FFFF;
        k = $urandom_range(0, 31);
        return (one << k) - one;
    endfunction

    logic [31:0] codes34 [4] = '{32'h1, 32'h3, 32'h7, 32'hF};
    int lat;
    int k34;
    int prev;

    initial begin
        #3;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.valid", 32'(res_valid), 0);
        chk("rst.data", 32'(res_data), 0);
        chk("rst.sat", 32'(sat), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(0, 0, 0, 32'h0, "idle");

        // Latency and value with a half-full code.
        step(1, 0, 0, 32'h0000_FFFF, "s33");
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            step(0, 0, 0, 32'h0000_FFFF, "r33");
            if (res_valid) begin lat = i; break; end
        end
        chk("lat33", 32'(lat), 32'(T));
        chk("data33", 32'(res_data), 16);
        chk("sat33", 32'(sat), 0);
        step(0, 0, 1, 32'h0, "ack33");

        // Per-sample codes 1,3,7,F with garbage between samples.
        step(1, 0, 0, $urandom(), "s34");
        k34 = 0;
        for (int i = 0; i < 60 && m_mode == 1; i++) begin
            if (is_sample_slot()) begin
                step(0, 0, 0, codes34[k34], "r34");
                k34++;
            end else begin
                step(0, 0, 0, $urandom(), "r34");
            end
        end
        chk("data34", 32'(res_data), 2);
        step(0, 0, 1, 32'h0, "ack34");

        // Saturated run, then hold result against a stalled consumer.
        step(1, 0, 0, 32'hFFFF_FFFF, "s34b");
        for (int i = 0; i < 60 && m_mode == 1; i++) step(0, 0, 0, 32'hFFFF_FFFF, "r34b");
        chk("data34b", 32'(res_data), 31);
        chk("sat34b", 32'(sat), 1);
        for (int i = 0; i < 5; i++) step(i == 2, 0, 0, $urandom(), "hold35");
        chk("valid35", 32'(res_valid), 1);
        step(0, 0, 1, 32'h0, "ack35");
        chk("busy35", 32'(busy), 0);

        // Abort with res_ready in the settle phase of the third sample.
        prev = 32'(res_data);
        step(1, 0, 0, 32'h0000_00FF, "s36");
        for (int i = 0; i < 60 && m_t != 2 * (S + 1); i++) step(0, 0, 0, 32'h0000_00FF, "r36");
        step(0, 1, 1, 32'h0, "ab36");
        chk("busy36", 32'(busy), 0);
        chk("data36", 32'(res_data), 32'(prev));
        step(1, 1, 0, 32'h0, "abst36");
        chk("busy36b", 32'(busy), 0);
        for (int i = 0; i < T + 2; i++) step(0, 0, 1, 32'h0, "quiet36");

        // Bubble code held for a whole measurement.
        step(1, 0, 0, 32'h0000_00F7, "s37");
        for (int i = 0; i < 60 && m_mode == 1; i++) step(0, 0, 0, 32'h0000_00F7, "r37");
`ifdef TDC_BUBBLE_FIX_EN
        chk("data37", 32'(res_data), 3);
`else
        chk("data37", 32'(res_data), 7);
`endif
        step(0, 0, 1, 32'h0, "ack37");

        // Reset in the middle of SETTLE.
        step(1, 0, 0, 32'hFFFF_FFFF, "s32");
        step(0, 0, 0, 32'hFFFF_FFFF, "r32");
        #2 rst_n = 1'b0;
        #1;
        m_mode = 0; m_res = 0; m_sat = 1'b0;
        chk("rst32.busy", 32'(busy), 0);
        chk("rst32.valid", 32'(res_valid), 0);
        chk("rst32.data", 32'(res_data), 0);
        chk("rst32.sat", 32'(sat), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < T + 3; i++) step(0, 0, $urandom_range(0, 1), 32'hFFFF_FFFF, "post32");

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 1), rand_code(), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
